// File: rtl/tetris_button_conditioner.sv
// Debounces four raw board buttons and turns presses into one-cycle move/drop/hold pulses,
// with auto-repeat on right and left.
//
// state     | meaning
// ST_IDLE   | waiting for a fresh press (level 0->1 while enabled)
// ST_DELAY  | right/left held, counting down to the first auto-repeat pulse
// ST_REPEAT | right/left held, pulsing every REPEAT_RATE cycles
// ST_HELD   | down/hold already fired for this press, waiting for release
module tetris_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 20_000_000,
  parameter int unsigned REPEAT_RATE     = 8_000_000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] raw_btn,
  output logic       right_move_button,
  output logic       left_move_button,
  output logic       direct_down_button,
  output logic       hold_button,
  output logic [3:0] btn_level
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] level;
  logic [3:0] level_q;
  logic [3:0] press;
  logic [3:0] fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_btn;
      sync_b <= sync_a;
    end
  end

  // Level only moves after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CNT_W-1:0] db_cnt;
    logic             lvl;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else if (sync_b[i] == lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        lvl    <= sync_b[i];
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end

    assign level[i] = lvl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  // Edge-based press, so a button held across enable=0 never fires on re-enable.
  assign press = level & ~level_q;

  for (genvar i = 0; i < 2; i++) begin : g_rep
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    logic             fire_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      fire_d  = 1'b0;
      if (!enable) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press[i]) begin
              fire_d  = 1'b1;
              state_d = ST_DELAY;
              rcnt_d  = '0;
            end
          end
          ST_DELAY: begin
            if (!level[i]) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == DELAY_LAST) begin
              fire_d  = 1'b1;
              state_d = ST_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (!level[i]) begin
              state_d = ST_IDLE;
              rcnt_d  = '0;
            end else if (rcnt_q == RATE_LAST) begin
              fire_d = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    assign fire[i] = fire_d;
  end

  for (genvar i = 2; i < 4; i++) begin : g_once
    state_t state_q;
    state_t state_d;
    logic   fire_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      fire_d  = 1'b0;
      if (!enable) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press[i]) begin
              fire_d  = 1'b1;
              state_d = ST_HELD;
            end
          end
          ST_HELD: begin
            if (!level[i]) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    assign fire[i] = fire_d;
  end

  // Simultaneous right+left is ambiguous, so both are dropped; the FSMs still advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      right_move_button  <= 1'b0;
      left_move_button   <= 1'b0;
      direct_down_button <= 1'b0;
      hold_button        <= 1'b0;
    end else begin
      right_move_button  <= fire[0] & ~fire[1];
      left_move_button   <= fire[1] & ~fire[0];
      direct_down_button <= fire[2];
      hold_button        <= fire[3];
    end
  end

  assign btn_level = level;

endmodule

// File: tb/tb_tetris_button_conditioner.sv
// Bench for tetris_button_conditioner: directed vector table, hand sequences for reset/enable
// corners, and random stimulus checked every cycle against an event-time reference model.
module tb_tetris_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] raw_btn = '0;
  logic       right_move_button;
  logic       left_move_button;
  logic       direct_down_button;
  logic       hold_button;
  logic [3:0] btn_level;
  logic [7:0] dut_out;
  logic [3:0] dut_pulses;

  int total = 0;
  int bad   = 0;

  tetris_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (25)
  ) dut (
    .clk               (clk),
    .reset             (reset_n),
    .enable            (enable),
    .raw_btn           (raw_btn),
    .right_move_button (right_move_button),
    .left_move_button  (left_move_button),
    .direct_down_button(direct_down_button),
    .hold_button       (hold_button),
    .btn_level         (btn_level)
  );

  always #5 clk = ~clk;

  assign dut_pulses = {hold_button, direct_down_button, left_move_button, right_move_button};
  assign dut_out    = {btn_level, dut_pulses};

  // Reference model: level flips once the two-edge-delayed raw value has run D samples
  // against it; pulses are placed by arithmetic on the time since the press edge.
  logic [3:0] m_seen1  = '0;
  logic [3:0] m_seen2  = '0;
  logic [3:0] m_last_s = '0;
  logic [3:0] m_lvl    = '0;
  logic [3:0] m_lvl_q  = '0;
  logic [3:0] m_armed  = '0;
  int         m_run   [4] = '{0, 0, 0, 0};
  int         m_press [4] = '{0, 0, 0, 0};
  int         m_edge = 0;
  logic [7:0] m_exp  = '0;

  always @(posedge clk) begin : ref_model
    logic [3:0] s;
    logic [3:0] f;
    logic [3:0] lvl_new;
    int         dt;
    if (!reset_n) begin
      m_seen1  = '0;
      m_seen2  = '0;
      m_last_s = '0;
      m_lvl    = '0;
      m_lvl_q  = '0;
      m_armed  = '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i]   = 0;
        m_press[i] = 0;
      end
      m_exp = '0;
    end else begin
      m_edge++;
      s       = m_seen2;
      m_seen2 = m_seen1;
      m_seen1 = raw_btn;
      f       = '0;
      lvl_new = m_lvl;
      for (int i = 0; i < 4; i++) begin
        m_run[i]    = (s[i] == m_last_s[i]) ? m_run[i] + 1 : 1;
        m_last_s[i] = s[i];
        if (s[i] != m_lvl[i] && m_run[i] >= D) lvl_new[i] = s[i];
        if (!enable) begin
          m_armed[i] = 1'b0;
        end else if (m_lvl[i] && !m_lvl_q[i]) begin
          m_armed[i] = 1'b1;
          m_press[i] = m_edge;
          f[i]       = 1'b1;
        end else if (!m_lvl[i]) begin
          m_armed[i] = 1'b0;
        end else if (m_armed[i] && i < 2) begin
          dt   = m_edge - m_press[i];
          f[i] = (dt == RD) || (dt > RD && ((dt - RD) % RR) == 0);
        end
      end
      m_lvl_q = m_lvl;
      m_lvl   = lvl_new;
      m_exp   = {lvl_new, f[3], f[2], f[1] & ~f[0], f[0] & ~f[1]};
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("model", dut_out, m_exp);
  endtask

  typedef struct {
    string      name;
    logic [3:0] mask;
    int         out_sel;
    logic [7:0] lead;
    int         lead_len;
    int         hold;
    int         exp_edge [6];
    int         n_exp;
    int         exp_rises;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    int         n;
    int         rises;
    logic [3:0] prev_lvl;
    logic [3:0] want;
    logic       bit_v;
    n        = v.lead_len + v.hold + 14;
    rises    = 0;
    prev_lvl = btn_level;
    for (int c = 0; c < n; c++) begin
      if (c < v.lead_len) bit_v = v.lead[c];
      else if (c < v.lead_len + v.hold) bit_v = 1'b1;
      else bit_v = 1'b0;
      raw_btn = bit_v ? v.mask : 4'b0000;
      step();
      want = '0;
      for (int j = 0; j < v.n_exp; j++)
        if (v.exp_edge[j] == c + 1) want = 4'b0001 << v.out_sel;
      check({v.name, "_pulse"}, {4'b0, dut_pulses}, {4'b0, want});
      rises   += $countones(btn_level & ~prev_lvl & v.mask);
      prev_lvl = btn_level;
    end
    check({v.name, "_rises"}, 8'(rises), 8'(v.exp_rises));
  endtask

  initial begin
    vecs[0] = '{"right_hold60",  4'b0001, 0, 8'h00, 0, 60, '{7, 27, 35, 43, 51, 59}, 6, 1};
    vecs[1] = '{"down_bounce",   4'b0100, 2, 8'h05, 4, 30, '{11, 0, 0, 0, 0, 0},     1, 1};
    vecs[2] = '{"hold_glitch2",  4'b1000, 3, 8'h03, 2, 0,  '{0, 0, 0, 0, 0, 0},      0, 0};
    vecs[3] = '{"right_left",    4'b0011, 0, 8'h00, 0, 10, '{0, 0, 0, 0, 0, 0},      0, 2};
    vecs[4] = '{"left_hold40",   4'b0010, 1, 8'h00, 0, 40, '{7, 27, 35, 43, 0, 0},   4, 1};
    vecs[5] = '{"down_glitch3",  4'b0100, 2, 8'h07, 3, 0,  '{0, 0, 0, 0, 0, 0},      0, 0};
    vecs[6] = '{"down_exact4",   4'b0100, 2, 8'h00, 0, 4,  '{7, 0, 0, 0, 0, 0},      1, 1};

    reset_n = 1'b0;
    step();
    step();
    check("reset_state", dut_out, 8'h00);
    reset_n = 1'b1;
    repeat (5) step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in the middle of an auto-repeat
    raw_btn = 4'b0001;
    repeat (30) step();
    check("t5_held_level", {7'b0, btn_level[0]}, 8'h01);
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_in_reset", dut_out, 8'h00);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 22; c++) begin
      step();
      check("t5_after_reset", {4'b0, dut_pulses}, (c + 1 == 7) ? 8'h01 : 8'h00);
    end
    raw_btn = 4'b0000;
    repeat (14) step();

    // press while disabled, then re-enable with the button held
    enable  = 1'b0;
    raw_btn = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      step();
      check("t6_disabled", {4'b0, dut_pulses}, 8'h00);
    end
    check("t6_level_while_off", {7'b0, btn_level[1]}, 8'h01);
    enable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      check("t6_reenabled_held", {4'b0, dut_pulses}, 8'h00);
    end
    raw_btn = 4'b0000;
    repeat (12) step();
    raw_btn = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t6_repress", {4'b0, dut_pulses}, (c + 1 == 7) ? 8'h02 : 8'h00);
    end
    raw_btn = 4'b0000;
    repeat (14) step();

    // random stimulus, flip rate varied per segment
    for (int seg = 0; seg < 24; seg++) begin
      int rate;
      case (seg % 3)
        0:       rate = 3;
        1:       rate = 12;
        default: rate = 45;
      endcase
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(rate - 1, 0) == 0) raw_btn[b] = ~raw_btn[b];
        if ($urandom_range(299, 0) == 0) enable = ~enable;
        reset_n = ($urandom_range(999, 0) != 0);
        step();
      end
    end
    reset_n = 1'b1;
    enable  = 1'b1;
    raw_btn = 4'b0000;
    repeat (14) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
